// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : 32x8 RAM responder with read wait states, one output port
//                 at IO_ADDR, and a sticky protocol-error flag.
// Revision      : 1.0
// ============================================================================
module mem_responder #(
   parameter int         WAIT_STATES = 0,
   parameter logic [4:0] IO_ADDR     = 5'h1F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] addr,
   input  logic       rd,
   input  logic       wr,
   input  logic       data_e,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       ready,
   output logic [7:0] io_out,
   output logic       io_strobe,
   output logic       proto_err
);

   localparam logic [1:0] c_wait_states = WAIT_STATES[1:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_cnt;
   logic [4:0] r_addr;
   logic       r_rd_q;
   logic       r_wr_q;
   logic [7:0] r_mem [32];

   logic w_rd_req;
   logic w_wr_req;
   logic w_idle;
   logic w_err;
   logic w_rd_ok;
   logic w_wr_ok;

   assign w_rd_req = rd & ~r_rd_q;
   assign w_wr_req = wr & ~r_wr_q;
   assign w_idle   = (r_state == ST_IDLE);

   // Any illegal edge is dropped entirely; only the sticky flag records it.
   assign w_err   = (w_wr_req & ~data_e)
                  | (w_rd_req & w_wr_req)
                  | ((w_rd_req | w_wr_req) & ~w_idle);
   assign w_rd_ok = w_rd_req & ~w_wr_req & w_idle;
   assign w_wr_ok = w_wr_req & ~w_rd_req & data_e & w_idle;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 2'd0;
         r_addr     <= 5'd0;
         r_rd_q     <= 1'b0;
         r_wr_q     <= 1'b0;
         data_out   <= 8'd0;
         data_valid <= 1'b0;
         ready      <= 1'b1;
         io_out     <= 8'd0;
         io_strobe  <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         r_rd_q     <= rd;
         r_wr_q     <= wr;
         data_valid <= 1'b0;
         io_strobe  <= 1'b0;
         if (w_err)
            proto_err <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_rd_ok) begin
                  r_addr  <= addr;
                  r_cnt   <= c_wait_states;
                  ready   <= 1'b0;
                  r_state <= (c_wait_states != 2'd0) ? ST_WAIT : ST_RESP;
               end else if (w_wr_ok && addr == IO_ADDR) begin
                  io_out    <= data_in;
                  io_strobe <= 1'b1;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 2'd1;
               if (r_cnt == 2'd1)
                  r_state <= ST_RESP;
            end
            ST_RESP: begin
               data_out   <= (r_addr == IO_ADDR) ? io_out : r_mem[r_addr];
               data_valid <= 1'b1;
               ready      <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // RAM has no reset; the port address never reaches the array.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok && addr != IO_ADDR)
         r_mem[addr] <= data_in;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder : scoreboard bench, instance 0 with no wait states and
//                    instance 1 with two wait states.
// Revision         : 1.0
// ============================================================================
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rd_s   [2];
   logic       wr_s   [2];
   logic       de_s   [2];
   logic [4:0] addr_s [2];
   logic [7:0] din_s  [2];
   logic [7:0] dout_s [2];
   logic [7:0] io_s   [2];
   logic       dv_s   [2];
   logic       rdy_s  [2];
   logic       stb_s  [2];
   logic       perr_s [2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   mem_responder #(.WAIT_STATES(0), .IO_ADDR(5'h1F)) u_dut0 (
      .clk(clk), .rst(rst), .addr(addr_s[0]), .rd(rd_s[0]), .wr(wr_s[0]),
      .data_e(de_s[0]), .data_in(din_s[0]), .data_out(dout_s[0]),
      .data_valid(dv_s[0]), .ready(rdy_s[0]), .io_out(io_s[0]),
      .io_strobe(stb_s[0]), .proto_err(perr_s[0])
   );

   mem_responder #(.WAIT_STATES(2), .IO_ADDR(5'h1F)) u_dut1 (
      .clk(clk), .rst(rst), .addr(addr_s[1]), .rd(rd_s[1]), .wr(wr_s[1]),
      .data_e(de_s[1]), .data_in(din_s[1]), .data_out(dout_s[1]),
      .data_valid(dv_s[1]), .ready(rdy_s[1]), .io_out(io_s[1]),
      .io_strobe(stb_s[1]), .proto_err(perr_s[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int d, input logic [4:0] a, input logic [7:0] v, input logic e);
      addr_s[d] = a;
      din_s[d]  = v;
      de_s[d]   = e;
      wr_s[d]   = 1'b1;
      tick();
      wr_s[d]   = 1'b0;
   endtask

   task automatic issue_read(input int d, input logic [4:0] a, input logic [7:0] v);
      exp_t e;
      addr_s[d] = a;
      rd_s[d]   = 1'b1;
      e.data    = v;
      e.due     = cyc + 2 + ((d == 0) ? 0 : 2);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(input int d);
      exp_t e;
      logic got;
      got = 1'b0;
      if (d == 0 && q0.size() > 0) begin
         e = q0.pop_front(); got = 1'b1;
      end else if (d == 1 && q1.size() > 0) begin
         e = q1.pop_front(); got = 1'b1;
      end
      if (!got) begin
         n_chk++;
         $display("FAIL dut%0d unexpected data_valid: data_out %0h at cycle %0d, none expected",
                  d, dout_s[d], cyc);
      end else begin
         chk($sformatf("dut%0d read data", d), 32'(dout_s[d]), 32'(e.data));
         chk($sformatf("dut%0d read latency cycle", d), 32'(cyc), 32'(e.due));
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++)
         if (dv_s[d] === 1'b1) mon(d);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int low_cnt;
      logic [7:0] snap;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         rd_s[d] = 1'b0; wr_s[d] = 1'b0; de_s[d] = 1'b0;
         addr_s[d] = 5'd0; din_s[d] = 8'd0;
      end
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("reset data_out",   32'(dout_s[0]), 32'h0);
      chk("reset data_valid", 32'(dv_s[0]),   32'h0);
      chk("reset ready",      32'(rdy_s[0]),  32'h1);
      chk("reset io_out",     32'(io_s[0]),   32'h0);
      chk("reset io_strobe",  32'(stb_s[0]),  32'h0);
      chk("reset proto_err",  32'(perr_s[0]), 32'h0);
      chk("reset ready w2",   32'(rdy_s[1]),  32'h1);

      // W=0: write A5 to 03, read it back on the very next edge
      do_write(0, 5'h03, 8'hA5, 1'b1);
      chk("write keeps ready", 32'(rdy_s[0]), 32'h1);
      issue_read(0, 5'h03, 8'hA5);
      tick();
      chk("w0 ready low after rd edge", 32'(rdy_s[0]), 32'h0);
      rd_s[0] = 1'b0;
      tick();
      chk("w0 ready high in valid cycle", 32'(rdy_s[0]), 32'h1);
      tick();
      chk("w0 ready stays high", 32'(rdy_s[0]), 32'h1);

      // W=2: rd held high for 6 cycles
      do_write(1, 5'h03, 8'hA5, 1'b1);
      tick();
      issue_read(1, 5'h03, 8'hA5);
      low_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rdy_s[1] == 1'b0) low_cnt++;
      end
      rd_s[1] = 1'b0;
      tick();
      chk("w2 ready low cycles", 32'(low_cnt), 32'd3);
      chk("w2 held rd no proto_err", 32'(perr_s[1]), 32'h0);

      // Output port write and read-back
      snap = u_dut0.r_mem[31];
      do_write(0, 5'h1F, 8'h3C, 1'b1);
      chk("io_out after write", 32'(io_s[0]),  32'h3C);
      chk("io_strobe pulse",    32'(stb_s[0]), 32'h1);
      tick();
      chk("io_strobe one cycle", 32'(stb_s[0]), 32'h0);
      chk("ram[1F] untouched by port write", 32'(u_dut0.r_mem[31]), 32'(snap));
      issue_read(0, 5'h1F, 8'h3C);
      tick();
      rd_s[0] = 1'b0;
      tick(); tick();

      // Write with data_e low is an error and leaves RAM alone
      do_write(0, 5'h04, 8'h11, 1'b1);
      tick();
      do_write(0, 5'h04, 8'h99, 1'b0);
      chk("no data_e sets proto_err", 32'(perr_s[0]), 32'h1);
      chk("no data_e no io_strobe",   32'(stb_s[0]),  32'h0);
      tick();
      issue_read(0, 5'h04, 8'h11);
      tick();
      rd_s[0] = 1'b0;
      tick(); tick();
      chk("proto_err sticky", 32'(perr_s[0]), 32'h1);

      // Simultaneous rd and wr edges are both ignored
      addr_s[1] = 5'h03; din_s[1] = 8'h55; de_s[1] = 1'b1;
      rd_s[1] = 1'b1; wr_s[1] = 1'b1;
      tick();
      chk("rd+wr sets proto_err",  32'(perr_s[1]), 32'h1);
      chk("rd+wr no FSM advance",  32'(rdy_s[1]),  32'h1);
      rd_s[1] = 1'b0; wr_s[1] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst clears proto_err w0", 32'(perr_s[0]), 32'h0);
      chk("rst clears proto_err w2", 32'(perr_s[1]), 32'h0);

      // Second rd edge during WAIT is ignored; first read finishes with old data
      issue_read(1, 5'h03, 8'hA5);
      tick();
      rd_s[1] = 1'b0;
      tick();
      rd_s[1] = 1'b1; addr_s[1] = 5'h04;
      tick();
      chk("rd in WAIT sets proto_err", 32'(perr_s[1]), 32'h1);
      rd_s[1] = 1'b0;
      tick(); tick(); tick();

      // Reset while in WAIT aborts the read
      rst = 1'b1; tick(); rst = 1'b0;
      addr_s[1] = 5'h03; rd_s[1] = 1'b1;
      tick();
      chk("abort: ready low in WAIT", 32'(rdy_s[1]), 32'h0);
      rd_s[1] = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort: data_valid", 32'(dv_s[1]),   32'h0);
      chk("abort: data_out",   32'(dout_s[1]), 32'h0);
      chk("abort: ready",      32'(rdy_s[1]),  32'h1);
      tick(); tick(); tick(); tick();
      issue_read(1, 5'h03, 8'hA5);
      tick();
      rd_s[1] = 1'b0;
      tick(); tick(); tick(); tick();

      chk("w0 all reads answered", 32'(q0.size()), 32'd0);
      chk("w2 all reads answered", 32'(q1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU control bus: it services the read and write strobes that the controller issues each instruction cycle. Contents:
- 32×8 synchronous RAM with a programmable number of read wait states.
- One memory-mapped output port at the top address.
- Sticky protocol-error detection for illegal strobe combinations.

The responder sits between the controller/address mux and the accumulator data path.

## Interface
Parameters:
- WAIT_STATES, 0 — extra read-latency cycles, legal range 0..3.
- IO_ADDR, 5'h1F — address decoded as the output port instead of RAM.

Ports:
- clk  input  1  clock. Every register updates on its rising edge.
- rst  input  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- addr  input  5  address from the PC/IR address mux.
- rd  input  1  read strobe from the controller. Level; may be held high for several cycles.
- wr  input  1  write strobe from the controller.
- data_e  input  1  data-enable. Must be high whenever wr is high.
- data_in  input  8  write data from the accumulator path.
- data_out  output  8  read data. Holds its value until the next completed read.
- data_valid  output  1  one-cycle pulse: data_out has just been updated.
- ready  output  1  high when idle. Low while a read is in flight.
- io_out  output  8  output-port register.
- io_strobe  output  1  one-cycle pulse on each output-port write.
- proto_err  output  1  sticky protocol-error flag. Only rst clears it.

## Operation
- Requests are rising edges: rd_req = rd & ~rd_q and wr_req = wr & ~wr_q.
  - rd_q and wr_q are edge-detect registers, reset to 0.
  - A strobe that is already high when reset deasserts therefore counts as an edge on the first cycle.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, rd_req only: capture addr, load wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement counter each cycle. Go to RESP when counter reaches 1.
  - RESP: drive data_out = RAM[addr_q], or io_out when addr_q==IO_ADDR. Pulse data_valid. Return to IDLE.
- Write (IDLE, wr_req only, data_e=1):
  - addr==IO_ADDR: io_out<=data_in and io_strobe pulses. RAM is not written.
  - Otherwise RAM[addr]<=data_in.
  - The write completes in that edge. ready stays high and the FSM stays in IDLE.
- Error conditions: each sets proto_err=1, and the request is ignored (no RAM or port update, no FSM advance).
  - wr_req with data_e=0.
  - rd_req and wr_req on the same edge.
  - rd_req or wr_req while the FSM is not in IDLE.
- A level-held rd or wr that produces no new edge is neither an error nor a new request.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values:
  - data_out=0, data_valid=0, ready=1
  - io_out=0, io_strobe=0, proto_err=0
  - FSM=IDLE, counter=0, rd_q=0, wr_q=0
- Read latency: with rd_req sampled at edge k, data_out updates and data_valid=1 after edge k+1+WAIT_STATES.
  - data_valid is high for exactly one cycle.
  - ready is low for WAIT_STATES+1 cycles, starting after edge k, and high again in the data_valid cycle.
  - A new rd_req is accepted on the edge that ends the data_valid cycle.
- Write latency: with wr_req at edge k, the RAM or io_out value is visible after edge k.
  - io_strobe is high for the single cycle following edge k.
  - A read of the same address can issue at edge k+1.
- Read-after-write to IO_ADDR returns the current io_out value.
- Reset mid-read: the FSM returns to IDLE on that edge.
  - No data_valid is produced for the aborted read.
  - data_out is cleared to 0.
- addr changes after capture do not affect an in-flight read.

## Test plan
- Reset, WAIT_STATES=0: write 8'hA5 to 5'h03, then rd edge at 5'h03.
  - data_out=8'hA5 with data_valid one cycle after the rd edge.
  - ready low for exactly 1 cycle.
- WAIT_STATES=2: rd at 5'h03 held high 6 cycles.
  - Exactly one data_valid, 3 cycles after the edge.
  - ready low 3 cycles, proto_err stays 0.
- Write 8'h3C to IO_ADDR.
  - io_out=8'h3C with one io_strobe pulse.
  - A subsequent read of IO_ADDR returns 8'h3C.
  - RAM[5'h1F] is unchanged when checked via backdoor.
- wr edge with data_e=0 at 5'h04 (old value 8'h11).
  - proto_err=1 and stays 1; RAM[5'h04] stays 8'h11.
  - Only rst clears proto_err.
- Simultaneous rd and wr edges, and a second rd edge during WAIT.
  - Both ignored, proto_err=1.
  - The in-flight read still completes with the correct data.
- rst asserted in the WAIT state.
  - No data_valid; data_out=0, ready=1 next cycle.
  - A new read after reset completes normally.
